instr_fetch_unit: RTL

Fetch stage of the single-cycle teaching CPU. Holds the program counter, drives the 8-bit address of the 16-bit instruction ROM, and latches the returned word into the instruction register (IR) for the decoder. Services control-transfer redirects (JMP, taken BAN) from execute with a one-slot squash. Detects an all-zero HALT word and stops fetching.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/instr_fetch_unit_pc_reg.sv | 30 +++
 rtl/instr_fetch_unit.sv | 115 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the teaching CPU: widths, instruction fields,
// opcode encodings, the HALT word and the fetch-stage state type.
package cpu_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  // Instruction word layout: opcode in the top six bits, operand below.
  localparam int OP_HI = 15;
  localparam int OP_LO = 10;

  localparam logic [5:0] OP_CLA = 6'b000001;
  localparam logic [5:0] OP_COM = 6'b000010;
  localparam logic [5:0] OP_SHR = 6'b000011;
  localparam logic [5:0] OP_CSL = 6'b000100;
  localparam logic [5:0] OP_ADD = 6'b000110;
  localparam logic [5:0] OP_STA = 6'b000111;
  localparam logic [5:0] OP_LDA = 6'b001000;
  localparam logic [5:0] OP_JMP = 6'b001001;
  localparam logic [5:0] OP_BAN = 6'b001010;

  // An all-zero fetched word stops the fetch stage.
  localparam logic [DATA_W-1:0] HALT_WORD = 16'h0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter register: synchronous reset, load from a redirect,
// increment after a delivered fetch, otherwise hold. Wraps modulo 2^ADDR_W.
module pc_reg #(
  parameter int               ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_cnt_reg;

  // Load has priority over increment; the increment wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_cnt_reg <= RESET_PC;
    end else if (load) begin
      pc_cnt_reg <= load_val;
    end else if (inc) begin
      pc_cnt_reg <= pc_cnt_reg + ADDR_W'(1);
    end
  end

  assign pc = pc_cnt_reg;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, addresses the instruction ROM, latches the
// returned word into the IR, squashes one slot on a redirect and stops
// on the HALT word until a redirect restarts it.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W    = cpu_pkg::ADDR_W,
  parameter int                DATA_W    = cpu_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] HALT_WORD = cpu_pkg::HALT_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  fetch_state_t      state_reg, state_next;
  logic [DATA_W-1:0] ir_reg, ir_next;
  logic [ADDR_W-1:0] ir_pc_reg, ir_pc_next;
  logic              ir_valid_reg, ir_valid_next;
  logic [15:0]       fetch_count_reg, fetch_count_next;
  logic              pc_load, pc_inc;
  logic [ADDR_W-1:0] pc;

  pc_reg #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (pc_load),
    .load_val(jump_target),
    .inc     (pc_inc),
    .pc      (pc)
  );

  // Next-state logic: redirect beats advance; HALT ignores en entirely.
  always_comb begin
    state_next       = state_reg;
    ir_next          = ir_reg;
    ir_pc_next       = ir_pc_reg;
    ir_valid_next    = ir_valid_reg;
    fetch_count_next = fetch_count_reg;
    pc_load          = 1'b0;
    pc_inc           = 1'b0;
    case (state_reg)
      RUN: begin
        if (jump_en) begin
          // The slot fetched alongside the redirect is on the wrong path.
          pc_load       = 1'b1;
          ir_valid_next = 1'b0;
        end else if (en) begin
          if (rom_data == HALT_WORD) begin
            // PC stays on the HALT address so it is visible while stopped.
            state_next    = HALT;
            ir_valid_next = 1'b0;
          end else begin
            ir_next       = rom_data;
            ir_pc_next    = pc;
            ir_valid_next = 1'b1;
            pc_inc        = 1'b1;
            if (fetch_count_reg != 16'hFFFF) begin
              fetch_count_next = fetch_count_reg + 16'd1;
            end
          end
        end
      end
      HALT: begin
        ir_valid_next = 1'b0;
        if (jump_en) begin
          pc_load    = 1'b1;
          state_next = RUN;
        end
      end
      default: begin
        state_next    = RUN;
        ir_valid_next = 1'b0;
      end
    endcase
  end

  // State, IR and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= RUN;
      ir_reg          <= '0;
      ir_pc_reg       <= '0;
      ir_valid_reg    <= 1'b0;
      fetch_count_reg <= 16'd0;
    end else begin
      state_reg       <= state_next;
      ir_reg          <= ir_next;
      ir_pc_reg       <= ir_pc_next;
      ir_valid_reg    <= ir_valid_next;
      fetch_count_reg <= fetch_count_next;
    end
  end

  assign rom_addr    = pc;
  assign ir          = ir_reg;
  assign ir_pc       = ir_pc_reg;
  assign ir_valid    = ir_valid_reg;
  assign halted      = (state_reg == HALT);
  assign fetch_count = fetch_count_reg;

endmodule
